glitch_cmd_parser: RTL and testbench

Byte-level command decoder sitting directly downstream of the UART receiver in the glitcher. Consumes one received byte per `rx_valid_i` strobe, assembles opcode and big-endian argument bytes, and commits glitch configuration registers atomically. Also issues single-cycle arm/trigger pulses and drives the UART transmitter for status and acknowledge bytes. An inter-byte timeout discards partial commands.

---
 rtl/glitch_cmd_pkg.sv | 23 ++
 rtl/glitch_cmd_parser_if.sv | 18 +
 rtl/cmd_timeout.sv | 34 +++
 rtl/glitch_cmd_parser.sv | 188 ++++++++++++++++++
 tb/tb_glitch_cmd_parser.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/glitch_cmd_pkg.sv
// Shared opcodes, response constants and FSM state encoding for the glitch command parser.
package glitch_cmd_pkg;

    localparam logic [7:0] OP_SET_DELAY = 8'h01;
    localparam logic [7:0] OP_SET_PULSE = 8'h02;
    localparam logic [7:0] OP_ARM       = 8'h03;
    localparam logic [7:0] OP_TRIGGER   = 8'h04;
    localparam logic [7:0] OP_STATUS    = 8'h05;

    localparam logic [7:0] ACK_BYTE     = 8'hAA;

    typedef enum logic [1:0] {
        IDLE,
        ARGS,
        EXEC,
        RESP
    } state_e;

    function automatic logic is_known_op(input logic [7:0] op);
        return (op >= OP_SET_DELAY) && (op <= OP_STATUS);
    endfunction

endpackage

// File: rtl/glitch_cmd_parser_if.sv
// UART-side byte handshake between the receiver/transmitter and the command parser.
interface glitch_cmd_parser_if;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic       tx_busy_i;
    logic [7:0] tx_data_o;
    logic       tx_start_o;

    modport master (
        output rx_data_i, rx_valid_i, tx_busy_i,
        input  tx_data_o, tx_start_o
    );

    modport slave (
        input  rx_data_i, rx_valid_i, tx_busy_i,
        output tx_data_o, tx_start_o
    );
endinterface

// File: rtl/cmd_timeout.sv
// Inter-byte timeout: reloadable down-counter, expiry flagged when the count reaches zero.
module cmd_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= LOAD_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);
endmodule

// File: rtl/glitch_cmd_parser.sv
// Byte-level command decoder for the glitcher UART link.
// Define GLITCH_CMD_ACK_EN to acknowledge every executed non-STATUS command with 0xAA.
//
// state | meaning
// IDLE  | waiting for an opcode byte
// ARGS  | shifting argument bytes into the shadow register, timeout armed
// EXEC  | one cycle: commit shadow or emit arm/trigger pulse
// RESP  | waiting for the transmitter, then one tx_start pulse
module glitch_cmd_parser
    import glitch_cmd_pkg::*;
#(
    parameter int unsigned CLK_FREQ       = 50_000_000,
    parameter int unsigned DELAY_W        = 32,
    parameter int unsigned PULSE_W        = 16,
    parameter int unsigned TIMEOUT_CYCLES = CLK_FREQ / 10
) (
    input  logic                 clk,
    input  logic                 rst,
    glitch_cmd_parser_if.slave   uart,
    input  logic [6:0]           status_i,
    output logic [DELAY_W-1:0]   delay_o,
    output logic [PULSE_W-1:0]   pulse_o,
    output logic                 arm_o,
    output logic                 trigger_o,
    output logic                 err_o
);
    localparam int unsigned SHADOW_W = (DELAY_W > PULSE_W) ? DELAY_W : PULSE_W;
    localparam int unsigned ACNT_W   = $clog2(SHADOW_W / 8 + 1);

`ifdef GLITCH_CMD_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    state_e              state_q;
    logic [7:0]          opcode_q;
    logic [SHADOW_W-1:0] shadow_q;
    logic [ACNT_W-1:0]   arg_cnt_q;
    logic [DELAY_W-1:0]  delay_q;
    logic [PULSE_W-1:0]  pulse_q;
    logic                arm_q;
    logic                trigger_q;
    logic                err_q;
    logic                tx_start_q;
    logic [7:0]          tx_data_q;

    logic                rx_valid;
    logic [7:0]          rx_data;
    logic                tx_busy;
    logic                tmo_load;
    logic                tmo_en;
    logic                tmo_expired;
    logic                needs_resp;
    logic [7:0]          resp_byte_d;
    logic [SHADOW_W-1:0] shadow_d;

    assign rx_valid = uart.rx_valid_i;
    assign rx_data  = uart.rx_data_i;
    assign tx_busy  = uart.tx_busy_i;

    assign tmo_load    = rx_valid && ((state_q == IDLE) || (state_q == ARGS));
    assign tmo_en      = (state_q == ARGS);
    assign needs_resp  = (opcode_q == OP_STATUS) || ACK_EN;
    assign resp_byte_d = (opcode_q == OP_STATUS) ? {err_q, status_i} : ACK_BYTE;
    // Truncating cast keeps the newest bytes: MSB-first shift.
    assign shadow_d    = SHADOW_W'({shadow_q, rx_data});

    cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tmo_load),
        .en_i      (tmo_en),
        .expired_o (tmo_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            opcode_q   <= '0;
            shadow_q   <= '0;
            arg_cnt_q  <= '0;
            delay_q    <= '0;
            pulse_q    <= '0;
            arm_q      <= 1'b0;
            trigger_q  <= 1'b0;
            err_q      <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            arm_q      <= 1'b0;
            trigger_q  <= 1'b0;
            tx_start_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (rx_valid) begin
                        if (is_known_op(rx_data)) begin
                            opcode_q <= rx_data;
                            if (rx_data == OP_SET_DELAY) begin
                                arg_cnt_q <= ACNT_W'(DELAY_W / 8);
                                shadow_q  <= '0;
                                state_q   <= ARGS;
                            end else if (rx_data == OP_SET_PULSE) begin
                                arg_cnt_q <= ACNT_W'(PULSE_W / 8);
                                shadow_q  <= '0;
                                state_q   <= ARGS;
                            end else begin
                                // Pulses are registered here so they are high exactly during EXEC.
                                arm_q     <= (rx_data == OP_ARM);
                                trigger_q <= (rx_data == OP_TRIGGER);
                                state_q   <= EXEC;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end

                ARGS: begin
                    if (rx_valid) begin
                        shadow_q  <= shadow_d;
                        arg_cnt_q <= arg_cnt_q - ACNT_W'(1);
                        if (arg_cnt_q == ACNT_W'(1)) begin
                            state_q <= EXEC;
                        end
                    end else if (tmo_expired) begin
                        shadow_q <= '0;
                        err_q    <= 1'b1;
                        state_q  <= IDLE;
                    end
                end

                EXEC: begin
                    if (opcode_q == OP_SET_DELAY) begin
                        delay_q <= shadow_q[DELAY_W-1:0];
                    end
                    if (opcode_q == OP_SET_PULSE) begin
                        pulse_q <= shadow_q[PULSE_W-1:0];
                    end
                    if (needs_resp) begin
                        state_q <= RESP;
                        if (!tx_busy) begin
                            tx_start_q <= 1'b1;
                            tx_data_q  <= resp_byte_d;
                            if (opcode_q == OP_STATUS) begin
                                err_q <= 1'b0;
                            end
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                    if (rx_valid) begin
                        err_q <= 1'b1;
                    end
                end

                RESP: begin
                    if (tx_start_q) begin
                        state_q <= IDLE;
                    end else if (!tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= resp_byte_d;
                        if (opcode_q == OP_STATUS) begin
                            err_q <= 1'b0;
                        end
                    end
                    // A dropped byte outranks the status read-clear.
                    if (rx_valid) begin
                        err_q <= 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign delay_o         = delay_q;
    assign pulse_o         = pulse_q;
    assign arm_o           = arm_q;
    assign trigger_o       = trigger_q;
    assign err_o           = err_q;
    assign uart.tx_start_o = tx_start_q;
    assign uart.tx_data_o  = tx_data_q;
endmodule

// File: tb/tb_glitch_cmd_parser.sv
// Directed self-checking bench for glitch_cmd_parser; ack expectations follow GLITCH_CMD_ACK_EN.
module tb_glitch_cmd_parser;
    localparam int unsigned TMO = 20;

    logic        clk;
    logic        rst;
    logic [6:0]  status_i;
    logic [31:0] delay_o;
    logic [15:0] pulse_o;
    logic        arm_o;
    logic        trigger_o;
    logic        err_o;

    int n_tests;
    int n_fail;
    int arm_cnt;
    int trig_cnt;
    int tx_cnt;
    logic [7:0] last_tx;

    glitch_cmd_parser_if u_if ();

    glitch_cmd_parser #(
        .CLK_FREQ       (50_000_000),
        .DELAY_W        (32),
        .PULSE_W        (16),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart      (u_if.slave),
        .status_i  (status_i),
        .delay_o   (delay_o),
        .pulse_o   (pulse_o),
        .arm_o     (arm_o),
        .trigger_o (trigger_o),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (arm_o) arm_cnt++;
            if (trigger_o) trig_cnt++;
            if (u_if.tx_start_o) begin
                tx_cnt++;
                last_tx = u_if.tx_data_o;
                n_tests++;
                if (u_if.tx_busy_i !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tx_start_while_busy: tx_busy_i=%b required 0", u_if.tx_busy_i);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the strobe.
    task automatic send_byte(input logic [7:0] b);
        u_if.rx_data_i  = b;
        u_if.rx_valid_i = 1'b1;
        @(posedge clk); #1;
        u_if.rx_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++; if (delay_o !== 32'h0) begin n_fail++; $display("FAIL reset_delay: got %h expected 0", delay_o); end
        n_tests++; if (pulse_o !== 16'h0) begin n_fail++; $display("FAIL reset_pulse: got %h expected 0", pulse_o); end
        n_tests++; if (u_if.tx_data_o !== 8'h0) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 0", u_if.tx_data_o); end
        n_tests++; if (u_if.tx_start_o !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b expected 0", u_if.tx_start_o); end
        n_tests++; if (arm_o !== 1'b0 || trigger_o !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got arm=%b trig=%b expected 0 0", arm_o, trigger_o); end
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err_o); end
    endtask

    task automatic test_delay_write();
        int tx0;
        tx0 = tx_cnt;
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        n_tests++; if (delay_o !== 32'h0) begin n_fail++; $display("FAIL delay_early: got %h expected 0 during EXEC", delay_o); end
        @(posedge clk); #1;
        n_tests++; if (delay_o !== 32'h12345678) begin n_fail++; $display("FAIL delay_write: got %h expected 12345678", delay_o); end
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL delay_err: got %b expected 0", err_o); end
        repeat (3) @(posedge clk); #1;
`ifdef GLITCH_CMD_ACK_EN
        n_tests++; if (tx_cnt - tx0 !== 1 || last_tx !== 8'hAA) begin n_fail++; $display("FAIL delay_ack: got %0d tx last %h expected 1 tx of AA", tx_cnt - tx0, last_tx); end
`else
        n_tests++; if (tx_cnt !== tx0) begin n_fail++; $display("FAIL delay_no_ack: got %0d tx expected 0", tx_cnt - tx0); end
`endif
    endtask

    task automatic test_trigger();
        int tx0, t0;
        tx0 = tx_cnt;
        t0  = trig_cnt;
        send_byte(8'h04);
        n_tests++; if (trigger_o !== 1'b1) begin n_fail++; $display("FAIL trigger_high: got %b expected 1", trigger_o); end
        @(posedge clk); #1;
        n_tests++; if (trigger_o !== 1'b0) begin n_fail++; $display("FAIL trigger_one_cycle: got %b expected 0", trigger_o); end
        repeat (3) @(posedge clk); #1;
        n_tests++; if (trig_cnt - t0 !== 1) begin n_fail++; $display("FAIL trigger_count: got %0d expected 1", trig_cnt - t0); end
`ifdef GLITCH_CMD_ACK_EN
        n_tests++; if (tx_cnt - tx0 !== 1 || last_tx !== 8'hAA) begin n_fail++; $display("FAIL trigger_ack: got %0d tx last %h expected 1 tx of AA", tx_cnt - tx0, last_tx); end
`else
        n_tests++; if (tx_cnt !== tx0) begin n_fail++; $display("FAIL trigger_no_ack: got %0d tx expected 0", tx_cnt - tx0); end
`endif
    endtask

    task automatic test_timeout();
        send_byte(8'h02);
        send_byte(8'hAB);
        repeat (TMO + 1) @(posedge clk);
        #1;
        n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b expected 1", err_o); end
        n_tests++; if (pulse_o !== 16'h0) begin n_fail++; $display("FAIL timeout_discard: got %h expected 0", pulse_o); end
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h10);
        @(posedge clk); #1;
        n_tests++; if (pulse_o !== 16'h0010) begin n_fail++; $display("FAIL timeout_retry_pulse: got %h expected 0010", pulse_o); end
        n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL timeout_err_sticky: got %b expected 1", err_o); end
        repeat (3) @(posedge clk); #1;
    endtask

    task automatic test_status_busy();
        int tx0;
        logic got;
        tx0 = tx_cnt;
        status_i = 7'h05;
        u_if.tx_busy_i = 1'b1;
        send_byte(8'h05);
        repeat (50) @(posedge clk);
        #1;
        n_tests++; if (tx_cnt !== tx0) begin n_fail++; $display("FAIL status_held_by_busy: got %0d tx expected 0", tx_cnt - tx0); end
        u_if.tx_busy_i = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (tx_cnt != tx0) begin
                got = 1'b1;
                break;
            end
        end
        n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL status_tx_timeout: got no tx_start expected one within 10 cycles"); end
        n_tests++; if (last_tx !== 8'h85) begin n_fail++; $display("FAIL status_byte: got %h expected 85", last_tx); end
        @(posedge clk); #1;
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL status_err_clear: got %b expected 0", err_o); end
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_timeout_edge();
        send_byte(8'h02);
        send_byte(8'h00);
        repeat (TMO) @(posedge clk);
        #1;
        send_byte(8'h33);
        @(posedge clk); #1;
        n_tests++; if (pulse_o !== 16'h0033) begin n_fail++; $display("FAIL timeout_edge_pulse: got %h expected 0033", pulse_o); end
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL timeout_edge_err: got %b expected 0", err_o); end
        repeat (3) @(posedge clk); #1;
    endtask

    task automatic test_unknown();
        int tx0, a0, t0;
        tx0 = tx_cnt;
        a0  = arm_cnt;
        t0  = trig_cnt;
        send_byte(8'h7F);
        repeat (3) @(posedge clk); #1;
        n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL unknown_err: got %b expected 1", err_o); end
        n_tests++; if (delay_o !== 32'h12345678 || pulse_o !== 16'h0033) begin n_fail++; $display("FAIL unknown_regs: got %h/%h expected 12345678/0033", delay_o, pulse_o); end
        n_tests++; if (arm_cnt !== a0 || trig_cnt !== t0 || tx_cnt !== tx0) begin n_fail++; $display("FAIL unknown_pulses: got arm+%0d trig+%0d tx+%0d expected none", arm_cnt - a0, trig_cnt - t0, tx_cnt - tx0); end
    endtask

    task automatic test_status_fast();
        status_i = 7'h15;
        send_byte(8'h05);
        n_tests++; if (u_if.tx_start_o !== 1'b0) begin n_fail++; $display("FAIL status_fast_early: got %b expected 0 in EXEC", u_if.tx_start_o); end
        @(posedge clk); #1;
        n_tests++; if (u_if.tx_start_o !== 1'b1 || u_if.tx_data_o !== 8'h95) begin n_fail++; $display("FAIL status_fast_tx: got start=%b data=%h expected 1 95", u_if.tx_start_o, u_if.tx_data_o); end
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL status_fast_err: got %b expected 0", err_o); end
        @(posedge clk); #1;
        n_tests++; if (u_if.tx_start_o !== 1'b0) begin n_fail++; $display("FAIL status_fast_single: got %b expected 0", u_if.tx_start_o); end
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_exec_drop();
        int a0, t0;
        a0 = arm_cnt;
        t0 = trig_cnt;
        send_byte(8'h03);
        n_tests++; if (arm_o !== 1'b1) begin n_fail++; $display("FAIL exec_drop_arm: got %b expected 1", arm_o); end
        send_byte(8'h04);
        repeat (3) @(posedge clk); #1;
        n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL exec_drop_err: got %b expected 1", err_o); end
        n_tests++; if (arm_cnt - a0 !== 1 || trig_cnt !== t0) begin n_fail++; $display("FAIL exec_drop_pulses: got arm+%0d trig+%0d expected 1 0", arm_cnt - a0, trig_cnt - t0); end
    endtask

    task automatic test_reset_mid();
        int a0;
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst = 1'b1;
        #1;
        n_tests++; if (delay_o !== 32'h0 || err_o !== 1'b0) begin n_fail++; $display("FAIL reset_mid_clear: got delay=%h err=%b expected 0 0", delay_o, err_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        a0 = arm_cnt;
        send_byte(8'h03);
        n_tests++; if (arm_o !== 1'b1) begin n_fail++; $display("FAIL reset_mid_arm: got %b expected 1", arm_o); end
        @(posedge clk); #1;
        n_tests++; if (arm_o !== 1'b0) begin n_fail++; $display("FAIL reset_mid_arm_one_cycle: got %b expected 0", arm_o); end
        repeat (3) @(posedge clk); #1;
        n_tests++; if (arm_cnt - a0 !== 1) begin n_fail++; $display("FAIL reset_mid_arm_count: got %0d expected 1", arm_cnt - a0); end
        n_tests++; if (delay_o !== 32'h0) begin n_fail++; $display("FAIL reset_mid_delay: got %h expected 0", delay_o); end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        arm_cnt  = 0;
        trig_cnt = 0;
        tx_cnt   = 0;
        last_tx  = 8'h00;
        rst      = 1'b1;
        status_i = 7'h00;
        u_if.rx_data_i  = 8'h00;
        u_if.rx_valid_i = 1'b0;
        u_if.tx_busy_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        test_reset();
        test_delay_write();
        test_trigger();
        test_timeout();
        test_status_busy();
        test_timeout_edge();
        test_unknown();
        test_status_fast();
        test_exec_drop();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
